// File: rtl/spdif_subframe_sequencer.sv
// S/PDIF subframe builder and WIDTH-bit group sequencer toward the BMC encoder.
// Define SPDIF_SEQ_STATUS_EN to add o_frame_index and o_block_start.
module spdif_subframe_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk128,
   input  logic             reset,
   input  logic             i_enable,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [23:0]      i_left,
   input  logic [23:0]      i_right,
   input  logic             i_invalid,
   input  logic [31:0]      i_cs,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_underrun,
`ifdef SPDIF_SEQ_STATUS_EN
   output logic [7:0]       o_frame_index,
   output logic             o_block_start,
`endif
   output logic             o_active
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_STOP   = 2'd2;

   localparam int         GROUPS   = 64 / WIDTH;
   localparam logic [5:0] LAST_GRP = 6'(GROUPS - 1);

   localparam logic [7:0] PRE_B = 8'b1001_1100;
   localparam logic [7:0] PRE_M = 8'b1001_0011;
   localparam logic [7:0] PRE_W = 8'b1001_0110;

   logic [1:0]  state;
   logic [63:0] word;
   logic [63:0] nxt;
   logic [5:0]  grp;
   logic        is_right;
   logic        build_pend;
   logic [7:0]  frame_idx;
   logic [31:0] cs_reg;
   logic        hold_full;
   logic [23:0] hold_l;
   logic [23:0] hold_r;
   logic        hold_v;
   logic [23:0] r_samp;
   logic        r_v;
   logic        underrun;

   // Slots 4..31 are each coded "1b"; parity covers sample, V, U and C.
   function automatic logic [63:0] mk_word(
      input logic [7:0]  pre,
      input logic [23:0] s,
      input logic        v,
      input logic        c
   );
      logic [27:0] d;
      logic [63:0] w;
      d = {^{s, v, c}, c, 1'b0, v, s};
      w = '0;
      w[63:56] = pre;
      for (int k = 0; k < 28; k++) begin
         w[55-2*k] = 1'b1;
         w[54-2*k] = d[k];
      end
      return w;
   endfunction

   function automatic logic cs_bit(
      input logic [7:0]  idx,
      input logic [31:0] cs
   );
      return (idx < 8'd32) ? cs[idx[4:0]] : 1'b0;
   endfunction

   logic        accept;
   logic [7:0]  nidx;
   logic [7:0]  lidx;
   logic [23:0] l_samp;
   logic        l_v;
   logic        l_c;
   logic [63:0] l_word;
   logic [63:0] r_word;
   logic        do_left;

   assign o_valid    = (state != S_IDLE);
   assign o_active   = (state != S_IDLE);
   assign o_data     = word[63 -: WIDTH];
   assign o_underrun = underrun;
   assign i_ready    = !hold_full;
   assign accept     = o_valid && o_ready;

   always_comb begin
      nidx   = (frame_idx == 8'd191) ? 8'd0 : frame_idx + 8'd1;
      lidx   = (state == S_IDLE) ? 8'd0 : nidx;
      l_samp = hold_full ? hold_l : 24'd0;
      l_v    = hold_full ? hold_v : 1'b1;
      l_c    = (lidx == 8'd0) ? i_cs[0] : cs_bit(lidx, cs_reg);
      l_word = mk_word((lidx == 8'd0) ? PRE_B : PRE_M,
                       l_samp, l_v, l_c);
      r_word = mk_word(PRE_W, r_samp, r_v,
                       cs_bit(frame_idx, cs_reg));
      // No new left subframe is pulled from the hold register once stopping.
      do_left = ((state == S_IDLE) && i_enable) ||
                (build_pend && is_right &&
                 (state == S_STREAM) && i_enable);
   end

   always_ff @(posedge clk128 or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         word       <= '0;
         nxt        <= '0;
         grp        <= '0;
         is_right   <= 1'b0;
         build_pend <= 1'b0;
         frame_idx  <= '0;
         cs_reg     <= '0;
         hold_full  <= 1'b0;
         hold_l     <= '0;
         hold_r     <= '0;
         hold_v     <= 1'b0;
         r_samp     <= '0;
         r_v        <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (i_valid && i_ready) begin
            hold_full <= 1'b1;
            hold_l    <= i_left;
            hold_r    <= i_right;
            hold_v    <= i_invalid;
         end
         if (do_left) begin
            if (hold_full) hold_full <= 1'b0;
            r_samp   <= hold_full ? hold_r : 24'd0;
            r_v      <= l_v;
            underrun <= !hold_full;
            if (lidx == 8'd0) cs_reg <= i_cs;
         end
         if (state == S_IDLE) begin
            if (i_enable) begin
               state      <= S_STREAM;
               word       <= l_word;
               grp        <= '0;
               is_right   <= 1'b0;
               build_pend <= 1'b0;
            end
         end else begin
            if ((state == S_STREAM) && !i_enable) state <= S_STOP;
            if (build_pend) begin
               build_pend <= 1'b0;
               if (!is_right)    nxt <= r_word;
               else if (do_left) nxt <= l_word;
            end
            if (accept) begin
               if (grp == 6'd0) build_pend <= 1'b1;
               if (grp == LAST_GRP) begin
                  grp <= '0;
                  if ((state == S_STOP) && is_right) begin
                     state     <= S_IDLE;
                     word      <= '0;
                     is_right  <= 1'b0;
                     frame_idx <= '0;
                  end else begin
                     word     <= nxt;
                     is_right <= !is_right;
                     if (is_right) frame_idx <= nidx;
                  end
               end else begin
                  grp  <= grp + 6'd1;
                  word <= word << WIDTH;
               end
            end
         end
      end
   end

`ifdef SPDIF_SEQ_STATUS_EN
   logic block_start;

   assign o_frame_index = frame_idx;
   assign o_block_start = block_start;

   always_ff @(posedge clk128 or posedge reset) begin
      if (reset) begin
         block_start <= 1'b0;
      end else begin
         block_start <= accept && (grp == 6'd0) && !is_right &&
                        (frame_idx == 8'd0);
      end
   end
`endif

endmodule

// File: doc/spdif_subframe_sequencer.md
Name: spdif_subframe_sequencer

Overview:
- Builds complete S/PDIF subframes from stereo 24-bit PCM sample pairs: preamble, audio slots, V/U/C/P bits.
- Sequences them into the downstream BMC encoder as WIDTH-bit transition-code groups over a valid/ready handshake.
- Owns block/frame counting (192 frames), B/M/W preamble selection, even parity, and underrun substitution.
- Sits between the sample FIFO and the BMC encoder, in the clk128 domain (128 half-cells per stereo frame).

Parameters:
- WIDTH, 4, bits per group to the encoder. Must divide 64; legal values 2, 4, 8, 16.

Ports:
- clk128  in  1  half-cell clock.
- reset  in  1  reset, asynchronous, active-high.
- i_enable  in  1  run request; level-sensitive.
- i_valid  in  1  sample pair offered.
- i_ready  out  1  sample pair holding register empty.
- i_left  in  24  left sample, two's complement.
- i_right  in  24  right sample, two's complement.
- i_invalid  in  1  validity (V) flag for the pair.
- i_cs  in  32  channel-status bits 0..31 of the block; bits 32..191 are 0.
- o_valid  out  1  group valid to encoder.
- o_ready  in  1  encoder ready.
- o_data  out  WIDTH  transition-code group; MSB is sent first.
- o_underrun  out  1  one-cycle pulse when a left subframe is built with no sample held.
- o_active  out  1  sequencer is streaming.

Behaviour:
- Reset values: i_ready=1, o_valid=0, o_data=0, o_underrun=0, o_active=0, frame index=0, hold register empty.
- Transition code: 1 = toggle at half-cell start. Each subframe is 64 half-cells: 8 preamble + 28 slots x 2.
- Preamble codes, MSB first:
  - B = 8'b1001_1100 (frame 0 left).
  - M = 8'b1001_0011 (other left).
  - W = 8'b1001_0110 (all right).
- Each data slot is coded "1b", where b is the slot bit.
- Slot map:
  - Slots 4..27 carry the sample, LSB first.
  - Slot 28 = V (i_invalid).
  - Slot 29 = U = 0.
  - Slot 30 = C = channel-status bit [frame index] (0 for index >= 32).
  - Slot 31 = P, even parity over slots 4..30.
- i_cs is captured when building the frame-0 left subframe and held for the whole block.
- Hold register:
  - A pair is accepted on i_valid && i_ready.
  - i_ready=0 while a pair is held.
  - The pair is released (i_ready=1 next cycle) when the left subframe is built from it.
  - The right sample and V flag are kept for the following right subframe.
- State machine:
  - IDLE: o_valid=0, o_active=0. i_enable=1 moves to STREAM on the next cycle, with the frame-0 left word built.
  - STREAM: o_valid=1 continuously.
    - Each o_valid && o_ready shifts the 64-bit subframe word left by WIDTH.
    - After 64/WIDTH accepts, the prebuilt next word is loaded in the same cycle, so there is no bubble.
  - STOP: entered when i_enable falls. The current frame is completed through the end of its right subframe, then the FSM goes to IDLE. The frame index is reset to 0. A held pair is kept.
- Next-word build:
  - Occurs in the cycle after the first group of the current subframe is accepted.
  - A left build with the hold register empty substitutes sample 0 with V=1 and pulses o_underrun for one cycle.
  - The frame index still advances.
- Frame index:
  - Increments after each right subframe completes.
  - Wraps 191 -> 0; the following left subframe uses B.
- Stalls: when o_ready=0, o_data and o_valid hold. No group is skipped or repeated.
- i_enable re-asserted during STOP: STOP still completes, then IDLE for one cycle, then restart.
- Reset mid-stream: everything returns to reset values immediately; the held pair is discarded.

Optional Feature:
- Macro SPDIF_SEQ_STATUS_EN.
- Defined: adds output o_frame_index[7:0] (index of the subframe currently being shifted) and output o_block_start. o_block_start is a one-cycle pulse when the first group of a B subframe is accepted.
- Undefined: neither port exists and there are no related registers. Core behaviour is identical.

Test Plan:
- WIDTH=4, reset, i_enable=1, pair L=R=0, V=0, i_cs=0, o_ready always 1 -> left groups 9,C then fourteen A. Right groups 9,6 then fourteen A. Frame 1 left begins 9,3.
- L=24'h000001 -> left subframe group 2 = E, last group = B (P=1). o_underrun stays 0.
- No pair supplied after the first -> next left subframe carries V=1 (slot-28 code "11"), zero audio, and o_underrun pulses exactly once per left subframe.
- i_cs=32'h0000_0004 over 193 frames -> C=1 only in frame 2 (both channels). The preamble sequence is B at frames 0 and 192, M elsewhere.
- Randomized o_ready stalls -> group stream is identical to the no-stall reference, and o_data stays stable while o_ready=0.
- i_enable dropped mid left subframe -> remaining left and right groups complete, then o_valid=0 and o_active=0. Re-enable restarts with B; reset asserted mid-subframe -> o_valid=0 immediately.
